// File: rtl/dsp_mac_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : dsp_mac_seq_if
// Brief    : Request/result handshake bundle for the sequential tiled MAC.
// Revision : 1.0 - initial release
// ============================================================================
interface dsp_mac_seq_if #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_BITS = 2
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      a;
    logic [WIDTH-1:0]      b;
    logic [2*WIDTH-1:0]    c;
    logic [1:0]            mode;
    logic                  mac;
    logic [SHIFT_BITS-1:0] shift_amount;
    logic                  shift_dir;
    logic                  out_valid;
    logic                  out_ready;
    logic [2*WIDTH-1:0]    out;
    logic                  overflow;

    modport master (
        output in_valid, a, b, c, mode, mac, shift_amount, shift_dir, out_ready,
        input  in_ready, out_valid, out, overflow
    );

    modport slave (
        input  in_valid, a, b, c, mode, mac, shift_amount, shift_dir, out_ready,
        output in_ready, out_valid, out, overflow
    );
endinterface
`default_nettype wire

// File: rtl/dsp_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : dsp_mac_seq
// Brief    : Sequential unsigned multiply-accumulate using one TILE x TILE
//            multiplier, one tile product per cycle. Optional DSP_MAC_SEQ_SAT_EN
//            clamps the accumulator on carry-out instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module dsp_mac_seq #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_BITS = 2
) (
    input  logic         clk,
    input  logic         rst,
    dsp_mac_seq_if.slave bus
);
    localparam int c_TILE = WIDTH / 2;
    localparam int c_DW   = 2 * WIDTH;

    localparam logic [1:0] c_MODE_LL  = 2'd0;
    localparam logic [1:0] c_MODE_LF  = 2'd1;
    localparam logic [1:0] c_MODE_FF  = 2'd2;
    localparam logic [1:0] c_MODE_ADD = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              r_state;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [1:0]          r_mode;
    logic [1:0]          r_cnt;
    logic [c_DW-1:0]     r_acc;
    logic [c_DW-1:0]     r_prev;
    logic                r_ovf;
    logic                r_in_ready;
    logic                r_out_valid;

    logic [c_TILE-1:0]     w_tile_a;
    logic [c_TILE-1:0]     w_tile_b;
    logic [WIDTH-1:0]      w_prod;
    logic [c_DW:0]         w_prod_ext;
    logic [c_DW:0]         w_term;
    logic [c_DW:0]         w_sum;
    logic                  w_carry;
    logic [c_DW-1:0]       w_next_acc;
    logic [1:0]            w_last_cnt;
    logic [SHIFT_BITS-1:0] w_shamt;
    logic [c_DW-1:0]       w_prev_shift;
    logic [c_DW-1:0]       w_addend;

    // Pass counter bit 1 selects the a half, bit 0 the b half: (0,0),(0,1),(1,0),(1,1).
    always_comb begin
        w_tile_a   = r_cnt[1] ? r_a[WIDTH-1:c_TILE] : r_a[c_TILE-1:0];
        w_tile_b   = r_cnt[0] ? r_b[WIDTH-1:c_TILE] : r_b[c_TILE-1:0];
        w_prod     = (r_mode == c_MODE_ADD) ? '0
                   : ({{c_TILE{1'b0}}, w_tile_a} * {{c_TILE{1'b0}}, w_tile_b});
        w_prod_ext = {{(WIDTH + 1){1'b0}}, w_prod};
        case ({1'b0, r_cnt[1]} + {1'b0, r_cnt[0]})
            2'd0:    w_term = w_prod_ext;
            2'd1:    w_term = w_prod_ext << c_TILE;
            default: w_term = w_prod_ext << WIDTH;
        endcase
        w_sum   = {1'b0, r_acc} + w_term;
        w_carry = w_sum[c_DW];
`ifdef DSP_MAC_SEQ_SAT_EN
        w_next_acc = (w_carry || r_ovf) ? '1 : w_sum[c_DW-1:0];
`else
        w_next_acc = w_sum[c_DW-1:0];
`endif
    end

    always_comb begin
        case (r_mode)
            c_MODE_LL:  w_last_cnt = 2'd0;
            c_MODE_LF:  w_last_cnt = 2'd1;
            c_MODE_FF:  w_last_cnt = 2'd3;
            default:    w_last_cnt = 2'd0;
        endcase
    end

    // Addend is resolved at accept so later changes to mac/shift have no effect.
    always_comb begin
        w_shamt      = bus.shift_amount;
        w_prev_shift = bus.shift_dir ? (r_prev >> w_shamt) : (r_prev << w_shamt);
        w_addend     = bus.mac ? w_prev_shift : bus.c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_mode      <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_prev      <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a        <= bus.a;
                        r_b        <= bus.b;
                        r_mode     <= bus.mode;
                        r_acc      <= w_addend;
                        r_ovf      <= 1'b0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_acc <= w_next_acc;
                    r_ovf <= r_ovf | w_carry;
                    if (r_cnt == w_last_cnt) begin
                        r_out_valid <= 1'b1;
                        r_state     <= HOLD;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        r_prev      <= r_acc;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out       = r_acc;
    assign bus.overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp_mac_seq
// Brief    : Scoreboard bench for dsp_mac_seq with directed, hand-computed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsp_mac_seq;
    localparam int W  = 32;
    localparam int SB = 2;

    typedef struct {
        logic [63:0] out;
        logic        ovf;
        int          lat;
        int          stall;
        int          acc_cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_fail;
    exp_t sb[$];

    dsp_mac_seq_if #(.WIDTH(W), .SHIFT_BITS(SB)) bus ();

    dsp_mac_seq #(.WIDTH(W), .SHIFT_BITS(SB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        n_cmp  = 0;
        n_fail = 0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    task automatic issue(input logic [1:0] mode, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] c, input logic mac, input logic [1:0] sh,
                         input logic dir, input logic [63:0] eo, input logic eovf,
                         input int lat, input int stall, input bit push);
        exp_t e;
        bit   ok;
        @(posedge clk);
        #1;
        bus.in_valid     = 1'b1;
        bus.mode         = mode;
        bus.a            = a;
        bus.b            = b;
        bus.c            = c;
        bus.mac          = mac;
        bus.shift_amount = sh;
        bus.shift_dir    = dir;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            fail_now("accept_timeout");
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e.out     = eo;
        e.ovf     = eovf;
        e.lat     = lat;
        e.stall   = stall;
        e.acc_cyc = cyc;
        if (push) sb.push_back(e);
        // Operands may change freely once accepted.
        bus.in_valid     = 1'b0;
        bus.a            = $urandom;
        bus.b            = $urandom;
        bus.c            = {$urandom, $urandom};
        bus.mode         = 2'($urandom_range(3, 0));
        bus.mac          = 1'($urandom_range(1, 0));
        bus.shift_amount = 2'($urandom_range(3, 0));
        bus.shift_dir    = 1'($urandom_range(1, 0));
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("drain_timeout");
    endtask

    // Monitor: pops the scoreboard on each new result, then applies backpressure.
    initial begin
        exp_t e;
        bit   seen;
        int   stall_left;
        seen          = 1'b0;
        stall_left    = 0;
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen          = 1'b0;
                stall_left    = 0;
                bus.out_ready = 1'b0;
            end else if (bus.out_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_result: got 0x%0h expected no result", bus.out);
                        stall_left = 0;
                    end else begin
                        e = sb.pop_front();
                        chk("out", bus.out, e.out);
                        chk("overflow", 64'(bus.overflow), 64'(e.ovf));
                        chk("latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
                        stall_left = e.stall;
                    end
                    bus.out_ready = (stall_left == 0);
                end else if (stall_left > 0) begin
                    chk("hold_out", bus.out, e.out);
                    chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
                    stall_left--;
                    bus.out_ready = (stall_left == 0);
                end
            end else begin
                seen          = 1'b0;
                bus.out_ready = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit any_valid;
        rst              = 1'b1;
        bus.in_valid     = 1'b0;
        bus.a            = '0;
        bus.b            = '0;
        bus.c            = '0;
        bus.mode         = '0;
        bus.mac          = 1'b0;
        bus.shift_amount = '0;
        bus.shift_dir    = 1'b0;
        #3;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out", bus.out, 64'd0);
        chk("rst_overflow", 64'(bus.overflow), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // full x full, all ones, no carry
        issue(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 1'b0, 2'd0, 1'b0,
              64'hFFFF_FFFE_0000_0001, 1'b0, 4, 0, 1'b1);
        // low x low plus c, then reuse it shifted left by one
        issue(2'd0, 32'h0001_0003, 32'h0007_0005, 64'd7, 1'b0, 2'd0, 1'b0,
              64'd22, 1'b0, 1, 0, 1'b1);
        issue(2'd0, 32'd2, 32'd2, 64'hDEAD, 1'b1, 2'd1, 1'b0,
              64'd48, 1'b0, 1, 0, 1'b1);
        // low-a x full-b ignores upper half of a
        issue(2'd1, 32'h0009_0003, 32'h0002_0005, 64'd0, 1'b0, 2'd0, 1'b0,
              64'h0000_0000_0006_000F, 1'b0, 2, 0, 1'b1);
        // carry out of the accumulator
`ifdef DSP_MAC_SEQ_SAT_EN
        issue(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'd0, 1'b0,
              64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4, 0, 1'b1);
        issue(2'd3, 32'h1111_1111, 32'h2222_2222, 64'd0, 1'b1, 2'd2, 1'b1,
              64'h3FFF_FFFF_FFFF_FFFF, 1'b0, 1, 0, 1'b1);
`else
        issue(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'd0, 1'b0,
              64'hFFFF_FFFE_0000_0000, 1'b1, 4, 0, 1'b1);
        issue(2'd3, 32'h1111_1111, 32'h2222_2222, 64'd0, 1'b1, 2'd2, 1'b1,
              64'h3FFF_FFFF_8000_0000, 1'b0, 1, 0, 1'b1);
`endif
        // addend-only held for 5 cycles while a second request waits
        issue(2'd3, 32'hAAAA_AAAA, 32'h5555_5555, 64'h1234_5678_9ABC_DEF0, 1'b0, 2'd0, 1'b0,
              64'h1234_5678_9ABC_DEF0, 1'b0, 1, 5, 1'b1);
        issue(2'd1, 32'h0000_0010, 32'h0003_0002, 64'd1, 1'b0, 2'd0, 1'b0,
              64'h0000_0000_0030_0021, 1'b0, 2, 0, 1'b1);
        issue(2'd2, 32'h0002_0003, 32'h0004_0005, 64'h10, 1'b0, 2'd0, 1'b0,
              64'h0000_0008_0016_001F, 1'b0, 4, 0, 1'b1);
        drain();

        // reset during pass 2 of a full x full operation aborts it
        issue(2'd2, 32'h1234_5678, 32'h9ABC_DEF0, 64'h55, 1'b0, 2'd0, 1'b0,
              64'd0, 1'b0, 4, 0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_out", bus.out, 64'd0);
        chk("abort_overflow", 64'(bus.overflow), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        any_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) any_valid = 1'b1;
        end
        chk("abort_no_result", 64'(any_valid), 64'd0);
        chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
        // previous result was cleared, so mac addend is zero
        issue(2'd0, 32'd3, 32'd5, 64'hFFFF, 1'b1, 2'd1, 1'b0,
              64'd15, 1'b0, 1, 0, 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dsp_mac_seq.md
DSP_MAC_SEQ -- requirements
Module: dsp_mac_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width (even, >=4); TILE = WIDTH/2.
REQ-002 SHALL have parameter SHIFT_BITS, default 2, width of accumulator shift amount.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 Ports:
- clk  in  1  clock, rising edge
- rst  in  1  async active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request
- a  in  WIDTH  multiplicand, unsigned
- b  in  WIDTH  multiplier, unsigned
- c  in  2*WIDTH  external addend, unsigned
- mode  in  2  0 low x low, 1 low-a x full-b, 2 full x full, 3 addend only
- mac  in  1  1 use shifted previous result as addend, 0 use c
- shift_amount  in  SHIFT_BITS  previous-result shift distance
- shift_dir  in  1  0 left, 1 right (logical)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out  out  2*WIDTH  result
- overflow  out  1  carry out of 2*WIDTH bits occurred during this operation

Function
REQ-005 SHALL use one TILE x TILE multiplier and issue one tile product per cycle.
REQ-006 Pass count N SHALL be: mode 0 -> 1, mode 1 -> 2, mode 2 -> 4, mode 3 -> 1 (zero product).
REQ-007 Tile (i,j) (i = a half, j = b half, 0 = low) SHALL be added at bit offset TILE*(i+j); mode 0 uses (0,0); mode 1 uses (0,0),(0,1); mode 2 uses (0,0),(0,1),(1,0),(1,1), in that order.
REQ-008 States SHALL be IDLE, RUN, HOLD; in_ready = 1 only in IDLE; out_valid = 1 only in HOLD.
REQ-009 IDLE: on in_valid & in_ready SHALL register a, b, mode, addend and go to RUN with pass counter 0.
REQ-010 Addend SHALL be c when mac=0; when mac=1, the last delivered result shifted by shift_amount in shift_dir, zero-filled, discarded bits lost; 0 if no result since reset.
REQ-011 Addend and shift SHALL be sampled at accept, not later.
REQ-012 RUN: each cycle add current tile product to accumulator; after pass N-1 go to HOLD.
REQ-013 Latency: request accepted at edge T SHALL give out_valid at edge T+N.
REQ-014 Accumulation SHALL be modulo 2^(2*WIDTH); overflow = OR of all carry-outs of this operation.
REQ-015 HOLD: out and overflow SHALL stay stable until out_ready=1; on that edge go to IDLE and latch out as previous result for mac.
REQ-016 in_valid in RUN/HOLD SHALL be ignored; a, b, c, mode, mac may change freely after accept.
REQ-017 Operands and results are unsigned; no signed mode.

Reset
REQ-018 rst=1 SHALL asynchronously force IDLE, in_ready=1 (after release), out_valid=0, out=0, overflow=0, previous result invalid, counter 0.
REQ-019 rst during RUN or HOLD SHALL abort the operation with no result delivered.

Configuration
REQ-020 Macro DSP_MAC_SEQ_SAT_EN: defined -> on any carry-out the accumulator SHALL clamp to 2^(2*WIDTH)-1 and remain clamped for the rest of the operation, overflow=1; undefined -> wrap per REQ-014, no saturation logic present.

Verification (WIDTH=32)
REQ-021 mode 2, a=b=0xFFFFFFFF, c=0, mac=0 -> out=0xFFFFFFFE00000001, out_valid 4 cycles after accept, overflow=0.
REQ-022 mode 0, a=0x00010003, b=0x00070005, c=7 -> out=22 after 1 cycle; then mac=1, shift left 1, mode 0, a=2, b=2 -> out=48.
REQ-023 mode 1, a=0x00090003, b=0x00020005, c=0 -> out=0x6000F after 2 cycles.
REQ-024 mode 2, a=b=0xFFFFFFFF, c=0xFFFFFFFFFFFFFFFF -> overflow=1; out=0xFFFFFFFE00000000 without macro, 0xFFFFFFFFFFFFFFFF with DSP_MAC_SEQ_SAT_EN.
REQ-025 out_ready=0 for 5 cycles in HOLD with in_valid=1 -> out constant, in_ready=0, second request accepted only after out handshake.
REQ-026 rst pulse at pass 2 of mode 2 -> out_valid never rises for that op, out=0, next mac=1 op uses addend 0.
